pingpong_wr_ctrl: RTL and testbench

Write-side controller for the two-bank layer buffer behind `multi_one_to_two_demux`. It accepts a valid/ready stream of 16-bit feature words and writes a frame of `CELL_CNT` words into the selected bank. It then flips `select` to the other bank. A bank is not rewritten until the downstream consumer releases it, so the producer stalls rather than overwrite unread data.

---
 rtl/cnn_buf_pkg.sv | 14 +
 rtl/pingpong_bank_flags.sv | 27 ++
 rtl/pingpong_wr_ctrl.sv | 101 ++++++++++
 tb/tb_pingpong_wr_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared types and constants for the CNN layer ping-pong buffer.
package cnn_buf_pkg;
  localparam int BUF_DW   = 16;
  localparam int BUF_AW   = 16;
  localparam int FRT_CELL = 120;
  localparam int MID_CELL = 84;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    SWITCH    = 2'd2,
    WAIT_BANK = 2'd3
  } wr_state_t;
endpackage

// File: rtl/pingpong_bank_flags.sv
// Per-bank full flags: set by the last word of a frame, cleared by the consumer's rd_done.
// A set and a clear on the same bank in the same cycle leaves the bank full.
module pingpong_bank_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_set,
  input  logic       i_set_bank,
  input  logic [1:0] i_rd_done,
  output logic [1:0] o_bank_full
);
  logic [1:0] r_full;
  logic [1:0] w_set_vec;
  logic [1:0] w_full_nxt;

  always_comb begin
    w_set_vec = 2'b00;
    if (i_set) w_set_vec[i_set_bank] = 1'b1;
    w_full_nxt = w_set_vec | (r_full & ~i_rd_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_full <= 2'b00;
    else        r_full <= w_full_nxt;
  end

  assign o_bank_full = r_full;
endmodule

// File: rtl/pingpong_wr_ctrl.sv
// Write-side ping-pong controller: fills one bank per frame, then flips to the other,
// stalling the producer while the target bank still holds an unreleased frame.
module pingpong_wr_ctrl
  import cnn_buf_pkg::*;
#(
  parameter int unsigned CELL_CNT  = FRT_CELL,
  parameter int unsigned ADDR_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BUF_DW-1:0] in_data,
  output logic              in_ready,
  input  logic [1:0]        rd_done,
  output logic              we,
  output logic [BUF_DW-1:0] data,
  output logic [BUF_AW-1:0] addr,
  output logic              select,
  output logic [1:0]        bank_full,
  output logic              frame_done
);
  if (CELL_CNT < 1 || CELL_CNT > 65535 || (ADDR_BASE + CELL_CNT - 1) > 65535) begin : g_param_err
    $error("pingpong_wr_ctrl: CELL_CNT/ADDR_BASE out of 16-bit address range");
  end

  localparam logic [BUF_AW-1:0] LP_BASE = BUF_AW'(ADDR_BASE);
  localparam logic [15:0]       LP_LAST = 16'(CELL_CNT - 1);

  wr_state_t         r_state, w_state_nxt;
  logic [15:0]       r_cnt;
  logic              r_bank;
  logic              r_we, r_sel, r_fd;
  logic [BUF_DW-1:0] r_dat;
  logic [BUF_AW-1:0] r_addr;
  logic              w_accept, w_last;
  logic [1:0]        w_bank_full;

  assign w_accept = in_valid && (r_state == WRITE);
  assign w_last   = w_accept && (r_cnt == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      w_state_nxt = WRITE;
      WRITE:     if (w_last) w_state_nxt = SWITCH;
      // r_bank already points at the next bank here
      SWITCH:    w_state_nxt = w_bank_full[r_bank] ? WAIT_BANK : WRITE;
      WAIT_BANK: if (!w_bank_full[r_bank]) w_state_nxt = WRITE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bank  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
        if (w_last) r_bank <= ~r_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_dat  <= '0;
      r_addr <= '0;
      r_sel  <= 1'b0;
      r_fd   <= 1'b0;
    end else begin
      r_we <= w_accept;
      r_fd <= w_last;
      if (w_accept) begin
        r_dat  <= in_data;
        r_addr <= LP_BASE + r_cnt;
        r_sel  <= r_bank;
      end
    end
  end

  pingpong_bank_flags u_flags (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_set       (w_last),
    .i_set_bank  (r_bank),
    .i_rd_done   (rd_done),
    .o_bank_full (w_bank_full)
  );

  assign in_ready   = (r_state == WRITE);
  assign we         = r_we;
  assign data       = r_dat;
  assign addr       = r_addr;
  assign select     = r_sel;
  assign frame_done = r_fd;
  assign bank_full  = w_bank_full;
endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Directed bench for pingpong_wr_ctrl: a 120-word instance and a 1-word instance at base 0x10.
module tb_pingpong_wr_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_we, a_sel, a_fd;
  logic [15:0] a_din, a_dat, a_addr;
  logic [1:0]  a_rd, a_bf;
  logic        b_valid, b_ready, b_we, b_sel, b_fd;
  logic [15:0] b_din, b_dat, b_addr;
  logic [1:0]  b_rd, b_bf;

  int n_vec = 0;
  int n_err = 0;

  pingpong_wr_ctrl #(.CELL_CNT(120), .ADDR_BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_din), .in_ready(a_ready),
    .rd_done(a_rd), .we(a_we), .data(a_dat), .addr(a_addr), .select(a_sel),
    .bank_full(a_bf), .frame_done(a_fd)
  );

  pingpong_wr_ctrl #(.CELL_CNT(1), .ADDR_BASE(16'h0010)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_din), .in_ready(b_ready),
    .rd_done(b_rd), .we(b_we), .data(b_dat), .addr(b_addr), .select(b_sel),
    .bank_full(b_bf), .frame_done(b_fd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".we"}, 32'(a_we), 32'd0);
    chk({tag, ".data"}, 32'(a_dat), 32'd0);
    chk({tag, ".addr"}, 32'(a_addr), 32'd0);
    chk({tag, ".select"}, 32'(a_sel), 32'd0);
    chk({tag, ".bank_full"}, 32'(a_bf), 32'd0);
    chk({tag, ".frame_done"}, 32'(a_fd), 32'd0);
    chk({tag, ".in_ready"}, 32'(a_ready), 32'd0);
  endtask

  initial begin
    int acc;
    int guard;
    bit v;
    bit rd_sent;

    rst_n = 1'b0;
    a_valid = 1'b0; a_din = '0; a_rd = 2'b00;
    b_valid = 1'b0; b_din = '0; b_rd = 2'b00;
    #3;
    chk_a_zero("reset_a");
    chk("reset_b.in_ready", 32'(b_ready), 32'd0);
    chk("reset_b.bank_full", 32'(b_bf), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_to_write.in_ready", 32'(a_ready), 32'd1);

    // Frame 1 into bank 0, back-to-back words 0..119
    for (int k = 0; k < 120; k++) begin
      a_valid = 1'b1; a_din = 16'(k);
      tick();
      chk("f1.we", 32'(a_we), 32'd1);
      chk("f1.addr", 32'(a_addr), 32'(k));
      chk("f1.data", 32'(a_dat), 32'(k));
      chk("f1.select", 32'(a_sel), 32'd0);
      chk("f1.frame_done", 32'(a_fd), (k == 119) ? 32'd1 : 32'd0);
      chk("f1.bank_full", 32'(a_bf), (k == 119) ? 32'd1 : 32'd0);
    end
    chk("f1.switch_ready", 32'(a_ready), 32'd0);
    a_din = 16'hDEAD;
    tick();
    chk("bubble.we", 32'(a_we), 32'd0);
    chk("bubble.frame_done", 32'(a_fd), 32'd0);
    chk("bubble.addr_hold", 32'(a_addr), 32'd119);
    chk("bubble.data_hold", 32'(a_dat), 32'd119);
    chk("bubble.in_ready", 32'(a_ready), 32'd1);

    // Frame 2 into bank 1 with random gaps; rd_done on the empty bank 1 is ignored
    acc = 0; guard = 0; rd_sent = 1'b0;
    while (acc < 120 && guard < 2000) begin
      guard++;
      v = ($urandom_range(0, 3) != 0);
      a_valid = v; a_din = 16'(1000 + acc);
      if (acc == 10 && !rd_sent) begin
        a_rd = 2'b10; rd_sent = 1'b1;
      end
      tick();
      a_rd = 2'b00;
      if (v) begin
        chk("f2.we", 32'(a_we), 32'd1);
        chk("f2.addr", 32'(a_addr), 32'(acc));
        chk("f2.data", 32'(a_dat), 32'(1000 + acc));
        chk("f2.select", 32'(a_sel), 32'd1);
        acc++;
      end else begin
        chk("f2.gap_we", 32'(a_we), 32'd0);
        chk("f2.gap_addr", 32'(a_addr), (acc == 0) ? 32'd119 : 32'(acc - 1));
      end
      chk("f2.bank_full", 32'(a_bf), (acc == 120) ? 32'd3 : 32'd1);
    end
    chk("f2.completed", 32'(acc), 32'd120);

    // Both banks full: producer stalls until bank 0 is released
    a_valid = 1'b1; a_din = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.in_ready", 32'(a_ready), 32'd0);
      chk("stall.we", 32'(a_we), 32'd0);
    end
    a_rd = 2'b01;
    tick();
    a_rd = 2'b00;
    chk("release.bank_full", 32'(a_bf), 32'd2);
    chk("release.in_ready_m", 32'(a_ready), 32'd0);
    tick();
    chk("release.in_ready_m1", 32'(a_ready), 32'd1);

    // Frame 3 into bank 0; rd_done for bank 0 coincides with the last-word set
    for (int k = 0; k < 120; k++) begin
      a_din = 16'(2000 + k);
      a_rd = (k == 119) ? 2'b01 : 2'b00;
      tick();
      a_rd = 2'b00;
      chk("f3.we", 32'(a_we), 32'd1);
      chk("f3.addr", 32'(a_addr), 32'(k));
      chk("f3.select", 32'(a_sel), 32'd0);
    end
    chk("f3.set_wins", 32'(a_bf), 32'd3);
    chk("f3.frame_done", 32'(a_fd), 32'd1);
    tick();
    chk("f3.wait_ready", 32'(a_ready), 32'd0);
    a_rd = 2'b11;
    tick();
    a_rd = 2'b00;
    chk("clear_both.bank_full", 32'(a_bf), 32'd0);
    chk("clear_both.in_ready", 32'(a_ready), 32'd0);
    tick();
    chk("clear_both.in_ready_next", 32'(a_ready), 32'd1);

    // Frame 4 into bank 1, interrupted by reset after 57 words
    for (int k = 0; k < 57; k++) begin
      a_din = 16'(3000 + k);
      tick();
      chk("f4.addr", 32'(a_addr), 32'(k));
      chk("f4.select", 32'(a_sel), 32'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_a_zero("midreset");
    tick();
    rst_n = 1'b1;
    a_din = 16'd4000;
    tick();
    chk("restart.in_ready", 32'(a_ready), 32'd1);
    chk("restart.we", 32'(a_we), 32'd0);
    tick();
    chk("restart.we1", 32'(a_we), 32'd1);
    chk("restart.addr", 32'(a_addr), 32'd0);
    chk("restart.select", 32'(a_sel), 32'd0);
    chk("restart.data", 32'(a_dat), 32'd4000);
    a_valid = 1'b0;

    // Single-word frames at base 0x10
    b_valid = 1'b1; b_din = 16'h0AA0;
    tick();
    chk("b0.we", 32'(b_we), 32'd1);
    chk("b0.addr", 32'(b_addr), 32'h10);
    chk("b0.select", 32'(b_sel), 32'd0);
    chk("b0.frame_done", 32'(b_fd), 32'd1);
    chk("b0.bank_full", 32'(b_bf), 32'd1);
    b_din = 16'h0AA1;
    tick();
    chk("b_bubble.we", 32'(b_we), 32'd0);
    chk("b_bubble.in_ready", 32'(b_ready), 32'd1);
    tick();
    chk("b1.we", 32'(b_we), 32'd1);
    chk("b1.addr", 32'(b_addr), 32'h10);
    chk("b1.select", 32'(b_sel), 32'd1);
    chk("b1.data", 32'(b_dat), 32'h0AA1);
    chk("b1.bank_full", 32'(b_bf), 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_stall.we", 32'(b_we), 32'd0);
      chk("b_stall.in_ready", 32'(b_ready), 32'd0);
    end
    b_rd = 2'b01;
    tick();
    b_rd = 2'b00;
    chk("b_release.bank_full", 32'(b_bf), 32'd2);
    chk("b_release.in_ready_m", 32'(b_ready), 32'd0);
    tick();
    chk("b_release.in_ready_m1", 32'(b_ready), 32'd1);
    b_din = 16'h0AA2;
    tick();
    chk("b2.we", 32'(b_we), 32'd1);
    chk("b2.select", 32'(b_sel), 32'd0);
    chk("b2.addr", 32'(b_addr), 32'h10);
    chk("b2.data", 32'(b_dat), 32'h0AA2);
    chk("b2.bank_full", 32'(b_bf), 32'd3);
    b_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
